// File: rtl/mem_scan_pkg.sv
// ============================================================================
// Module   : mem_scan_pkg
// Purpose  : Shared types, mode encodings and the fill-pattern helper for the
//            mem_scan_ctrl memory scan initiator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_scan_pkg;

  // Scan controller states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Operation modes (2'b11 behaves like MODE_BOTH)
  localparam logic [1:0] MODE_FILL   = 2'b00;
  localparam logic [1:0] MODE_VERIFY = 2'b01;
  localparam logic [1:0] MODE_BOTH   = 2'b10;

  // One byte of the fill pattern: low address byte + seed + byte lane, mod 256
  function automatic logic [7:0] pattern_byte(input logic [7:0] addr_lo,
                                              input logic [7:0] seed,
                                              input logic [7:0] idx);
    return addr_lo + seed + idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_scan_cmp.sv
// ============================================================================
// Module   : mem_scan_cmp
// Purpose  : Registered read-back compare stage with saturating mismatch
//            counter. With MEM_SCAN_ERRLOG_EN defined it also captures the
//            address and data of the first mismatch of a verify pass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_scan_cmp #(
  parameter int W      = 1,
  parameter int Addr_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               sample_i,
  input  logic [Addr_W:0]    addr_i,
  input  logic [8*W-1:0]     rd_i,
  input  logic [8*W-1:0]     exp_i,
  output logic [CNT_W-1:0]   err_count_o,
  output logic [Addr_W:0]    first_err_addr_o,
  output logic [8*W-1:0]     first_err_data_o
);

  logic               valid_q;
  logic [8*W-1:0]     rd_q;
  logic [8*W-1:0]     exp_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               w_mismatch;

  assign w_mismatch  = valid_q && (rd_q != exp_q);
  assign err_count_o = cnt_q;

  // Next count: cleared by an accepted start, otherwise saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (w_mismatch && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Capture the combinational read data and expected pattern, update count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= sample_i && !clear_i;
      rd_q    <= rd_i;
      exp_q   <= exp_i;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MEM_SCAN_ERRLOG_EN
  logic [Addr_W:0]    addr_q;
  logic [Addr_W:0]    ferr_addr_q;
  logic [8*W-1:0]     ferr_data_q;

  // Address travels alongside the data so a capture names the right location;
  // the first mismatch is the one seen while the count is still zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
    end else begin
      addr_q <= addr_i;
      if (clear_i) begin
        ferr_addr_q <= '0;
        ferr_data_q <= '0;
      end else if (w_mismatch && (cnt_q == '0)) begin
        ferr_addr_q <= addr_q;
        ferr_data_q <= rd_q;
      end
    end
  end

  assign first_err_addr_o = ferr_addr_q;
  assign first_err_data_o = ferr_data_q;
`else
  logic w_unused_addr;
  assign w_unused_addr    = ^addr_i;
  assign first_err_addr_o = '0;
  assign first_err_data_o = '0;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_scan_ctrl.sv
// ============================================================================
// Module   : mem_scan_ctrl
// Purpose  : Sequential fill / verify initiator for the byte-wide single-port
//            memory. Fills [first..last] with an address+seed pattern, reads
//            it back through a registered compare stage, or both in sequence.
//            Optional first-failure logging: define MEM_SCAN_ERRLOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_scan_ctrl #(
  parameter int W      = 1,
  parameter int Addr_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inp_start,
  input  logic [1:0]         inp_mode,
  input  logic [Addr_W:0]    inp_first,
  input  logic [Addr_W:0]    inp_last,
  input  logic [7:0]         inp_seed,
  input  logic [8*W-1:0]     inp_read_data,
  output logic [Addr_W:0]    out_address,
  output logic [8*W-1:0]     out_data,
  output logic               out_write_enable,
  output logic               out_busy,
  output logic               out_done,
  output logic [CNT_W-1:0]   out_err_count,
  output logic               out_range_err,
  output logic [Addr_W:0]    out_first_err_addr,
  output logic [8*W-1:0]     out_first_err_data
);

  import mem_scan_pkg::*;

  // Full word pattern for an address: one pattern byte per lane
  function automatic logic [8*W-1:0] pattern_word(input logic [Addr_W:0] a,
                                                  input logic [7:0]      s);
    logic [8*W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      w[8*i +: 8] = pattern_byte(8'(a), s, 8'(i));
    end
    return w;
  endfunction

  state_t           state_q;
  logic [1:0]       mode_q;
  logic [Addr_W:0]  first_q;
  logic [Addr_W:0]  last_q;
  logic [7:0]       seed_q;
  logic [Addr_W:0]  addr_q;
  logic [8*W-1:0]   data_q;
  logic             we_q;
  logic             busy_q;
  logic             done_q;
  logic             range_err_q;

  logic             w_start;
  logic             w_sample;
  logic [Addr_W:0]  w_addr_nxt;
  logic [8*W-1:0]   w_exp;

  assign w_start    = (state_q == ST_IDLE) && inp_start;
  assign w_sample   = (state_q == ST_READ);
  assign w_addr_nxt = addr_q + 1'b1;
  assign w_exp      = pattern_word(addr_q, seed_q);

  // Scan sequencer: latches the command, steps the address, drives the memory
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= '0;
      first_q     <= '0;
      last_q      <= '0;
      seed_q      <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (inp_start) begin
            mode_q  <= inp_mode;
            first_q <= inp_first;
            last_q  <= inp_last;
            seed_q  <= inp_seed;
            if (inp_first > inp_last) begin
              range_err_q <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              range_err_q <= 1'b0;
              busy_q      <= 1'b1;
              addr_q      <= inp_first;
              if (inp_mode == MODE_VERIFY) begin
                state_q <= ST_READ;
              end else begin
                state_q <= ST_WRITE;
                we_q    <= 1'b1;
                data_q  <= pattern_word(inp_first, inp_seed);
              end
            end
          end
        end
        ST_WRITE: begin
          // Terminate on equality with last so a full-range scan never wraps
          if (addr_q == last_q) begin
            we_q <= 1'b0;
            if (mode_q == MODE_FILL) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              addr_q  <= first_q;
              state_q <= ST_READ;
            end
          end else begin
            addr_q <= w_addr_nxt;
            data_q <= pattern_word(w_addr_nxt, seed_q);
          end
        end
        ST_READ: begin
          if (addr_q == last_q) begin
            state_q <= ST_DRAIN;
          end else begin
            addr_q <= w_addr_nxt;
          end
        end
        ST_DRAIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  mem_scan_cmp #(
    .W      (W),
    .Addr_W (Addr_W),
    .CNT_W  (CNT_W)
  ) u_cmp (
    .clk              (clk),
    .reset            (reset),
    .clear_i          (w_start),
    .sample_i         (w_sample),
    .addr_i           (addr_q),
    .rd_i             (inp_read_data),
    .exp_i            (w_exp),
    .err_count_o      (out_err_count),
    .first_err_addr_o (out_first_err_addr),
    .first_err_data_o (out_first_err_data)
  );

  assign out_address      = addr_q;
  assign out_data         = data_q;
  assign out_write_enable = we_q;
  assign out_busy         = busy_q;
  assign out_done         = done_q;
  assign out_range_err    = range_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_scan_ctrl.sv
// ============================================================================
// Module   : tb_mem_scan_ctrl
// Purpose  : Scoreboard bench for mem_scan_ctrl with a behavioural memory.
//            Honours MEM_SCAN_ERRLOG_EN for the first-failure outputs.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_scan_ctrl;

  localparam int W     = 1;
  localparam int AW    = 8;
  localparam int CW    = 4;
  localparam int DEPTH = 512;
  localparam int SAT   = (1 << CW) - 1;

  localparam logic [1:0] M_FILL   = 2'b00;
  localparam logic [1:0] M_VERIFY = 2'b01;
  localparam logic [1:0] M_BOTH   = 2'b10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          inp_start = 1'b0;
  logic [1:0]    inp_mode = '0;
  logic [AW:0]   inp_first = '0;
  logic [AW:0]   inp_last = '0;
  logic [7:0]    inp_seed = '0;
  logic [7:0]    inp_read_data;
  logic [AW:0]   out_address;
  logic [7:0]    out_data;
  logic          out_write_enable;
  logic          out_busy;
  logic          out_done;
  logic [CW-1:0] out_err_count;
  logic          out_range_err;
  logic [AW:0]   out_first_err_addr;
  logic [7:0]    out_first_err_data;

  mem_scan_ctrl #(.W(W), .Addr_W(AW), .CNT_W(CW)) dut (
    .clk                (clk),
    .reset              (reset),
    .inp_start          (inp_start),
    .inp_mode           (inp_mode),
    .inp_first          (inp_first),
    .inp_last           (inp_last),
    .inp_seed           (inp_seed),
    .inp_read_data      (inp_read_data),
    .out_address        (out_address),
    .out_data           (out_data),
    .out_write_enable   (out_write_enable),
    .out_busy           (out_busy),
    .out_done           (out_done),
    .out_err_count      (out_err_count),
    .out_range_err      (out_range_err),
    .out_first_err_addr (out_first_err_addr),
    .out_first_err_data (out_first_err_data)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory plus a backdoor port for corruption
  logic [7:0] mem [DEPTH];
  logic       bd_we = 1'b0;
  logic [AW:0] bd_addr = '0;
  logic [7:0] bd_data = '0;
  always @(posedge clk) begin
    if (out_write_enable) mem[out_address] <= out_data;
    if (bd_we) mem[bd_addr] <= bd_data;
  end
  assign inp_read_data = mem[out_address];

  // Reference model state: what the memory should contain
  logic [7:0] ref_mem [DEPTH];

  typedef struct { int cyc; logic [AW:0] a; logic [7:0] d; } wr_t;
  typedef struct { int cyc; int cnt; bit rerr; logic [AW:0] fa; logic [7:0] fd; } dn_t;
  wr_t wq[$];
  dn_t dq[$];

  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  int  done_seen = 0;
  bit  mon_en = 1'b0;
  bit  op_active = 1'b0;
  int  op_c = 0;
  int  op_d = 0;
  wr_t mw;
  dn_t md;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] exp_byte(input int a, input logic [7:0] s);
    return 8'((a % 256) + int'(s));
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops expected write beats and completions as the DUT presents them
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", {31'd0, out_busy},
            {31'd0, op_active && (cyc - op_c >= 1) && (cyc - op_c <= op_d - 1)});
      if (out_write_enable) begin
        if (wq.size() == 0) begin
          check("unexpected_write_addr", {23'd0, out_address}, 32'hFFFF_FFFF);
        end else begin
          mw = wq.pop_front();
          check("wr_addr",  {23'd0, out_address}, {23'd0, mw.a});
          check("wr_data",  {24'd0, out_data}, {24'd0, mw.d});
          check("wr_cycle", cyc, mw.cyc);
        end
      end
      if (out_done) begin
        done_seen++;
        if (dq.size() == 0) begin
          check("unexpected_done_cycle", cyc, 32'hFFFF_FFFF);
        end else begin
          md = dq.pop_front();
          check("done_cycle",     cyc, md.cyc);
          check("err_count",      {28'd0, out_err_count}, md.cnt);
          check("range_err",      {31'd0, out_range_err}, {31'd0, md.rerr});
          check("first_err_addr", {23'd0, out_first_err_addr}, {23'd0, md.fa});
          check("first_err_data", {24'd0, out_first_err_data}, {24'd0, md.fd});
          check("writes_missing", wq.size(), 0);
        end
      end
    end
  end

  task automatic corrupt(input int a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = 9'(a); bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // Issue one operation: model pushes expectations, then drive start and wait
  task automatic run_op(input logic [1:0] mode, input int first, input int last,
                        input logic [7:0] seed, input bit pulse_busy);
    int  n, d, errs, c0, target, pk;
    bit  found;
    dn_t e;
    wr_t w;
    c0 = cyc;
    e.fa = '0; e.fd = '0; e.rerr = 1'b0;
    errs = 0; found = 1'b0; d = 1;
    if (first > last) begin
      e.rerr = 1'b1;
    end else begin
      n = last - first + 1;
      if (mode != M_VERIFY) begin
        for (int j = 0; j < n; j++) begin
          w.cyc = c0 + 1 + j; w.a = 9'(first + j); w.d = exp_byte(first + j, seed);
          wq.push_back(w);
          ref_mem[first + j] = w.d;
        end
      end
      if (mode != M_FILL) begin
        for (int a = first; a <= last; a++) begin
          if (ref_mem[a] != exp_byte(a, seed)) begin
            errs++;
            if (!found) begin found = 1'b1; e.fa = 9'(a); e.fd = ref_mem[a]; end
          end
        end
      end
      d = (mode == M_FILL) ? n + 1 : (mode == M_VERIFY) ? n + 2 : 2 * n + 2;
    end
    e.cnt = (errs > SAT) ? SAT : errs;
    e.cyc = c0 + d;
`ifndef MEM_SCAN_ERRLOG_EN
    e.fa = '0; e.fd = '0;
`endif
    dq.push_back(e);
    op_c = c0; op_d = d; op_active = 1'b1;
    target = done_seen + 1;
    pk = (pulse_busy && d >= 3) ? int'($urandom_range(2, d - 1)) : 0;
    inp_mode = mode; inp_first = 9'(first); inp_last = 9'(last); inp_seed = seed;
    inp_start = 1'b1;
    @(negedge clk);
    inp_start = 1'b0;
    inp_mode = 2'($urandom); inp_first = 9'($urandom); inp_last = 9'($urandom);
    inp_seed = 8'($urandom);
    for (int k = 2; k < d + 20 && done_seen < target; k++) begin
      @(negedge clk);
      inp_start = (k == pk);
    end
    inp_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (done_seen < target) check("done_timeout", done_seen, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s;
    bit found;
    int f, l;
    // Random initial memory contents, loaded while reset is held
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      bd_we = 1'b1; bd_addr = 9'(a); bd_data = 8'($urandom); ref_mem[a] = bd_data;
    end
    @(negedge clk);
    bd_we = 1'b0;
    check("rst_we",      {31'd0, out_write_enable}, 0);
    check("rst_busy",    {31'd0, out_busy}, 0);
    check("rst_done",    {31'd0, out_done}, 0);
    check("rst_addr",    {23'd0, out_address}, 0);
    check("rst_data",    {24'd0, out_data}, 0);
    check("rst_count",   {28'd0, out_err_count}, 0);
    check("rst_rangeerr", {31'd0, out_range_err}, 0);
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Fill + verify 00..03 seed 01, then a corrupted verify
    run_op(M_BOTH, 0, 3, 8'h01, 1'b0);
    corrupt(2, 8'hFF);
    run_op(M_VERIFY, 0, 3, 8'h01, 1'b0);

    // Range error, flag must hold until the next start
    run_op(M_FILL, 16, 15, 8'h33, 1'b0);
    repeat (3) @(negedge clk);
    check("range_err_hold", {31'd0, out_range_err}, 1);

    // Full-range fill, then full-range verify
    s = 8'($urandom);
    run_op(M_FILL, 0, DEPTH - 1, s, 1'b0);
    run_op(M_VERIFY, 0, DEPTH - 1, s, 1'b1);

    // Saturation with 20 injected errors and a start pulse while busy
    s = 8'($urandom);
    run_op(M_BOTH, 64, 95, s, 1'b0);
    for (int a = 64; a < 84; a++) corrupt(a, exp_byte(a, s) ^ 8'h5A);
    run_op(M_VERIFY, 64, 95, s, 1'b1);

    // Reset during the write to 0x05
    mon_en = 1'b0;
    s = 8'($urandom);
    inp_mode = M_FILL; inp_first = 9'h000; inp_last = 9'h020; inp_seed = s;
    inp_start = 1'b1;
    @(negedge clk);
    inp_start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (out_write_enable && out_address == 9'h005) found = 1'b1;
      else @(negedge clk);
    end
    check("reach_addr5", {31'd0, found}, 1);
    #1 reset = 1'b1;
    #1;
    check("midrst_we",    {31'd0, out_write_enable}, 0);
    check("midrst_busy",  {31'd0, out_busy}, 0);
    check("midrst_done",  {31'd0, out_done}, 0);
    check("midrst_addr",  {23'd0, out_address}, 0);
    check("midrst_count", {28'd0, out_err_count}, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 5; a++) ref_mem[a] = exp_byte(a, s);
    op_d = 0;
    @(negedge clk);
    mon_en = 1'b1;
    run_op(M_VERIFY, 0, 7, s, 1'b0);

    // Randomized operations
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int c = 0; c < int'($urandom_range(1, 3)); c++)
          corrupt(int'($urandom_range(0, DEPTH - 1)), 8'($urandom));
      end
      f = int'($urandom_range(0, DEPTH - 1));
      l = f + int'($urandom_range(0, 23));
      if (l > DEPTH - 1) l = DEPTH - 1;
      if ($urandom_range(0, 7) == 0 && f > 0) l = f - 1;
      run_op(2'($urandom), f, l, 8'($urandom), $urandom_range(0, 1) == 1);
    end

    check("done_queue_empty", dq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_scan_ctrl.md
# mem_scan_ctrl

Sequential initiator for the byte-wide single-port `memory` block. It drives `memory`'s address, data and write-enable inputs and consumes its read data. On a start pulse it fills an address range with a deterministic pattern, reads the range back and compares it, or does both in sequence. It reports busy/done, a saturating mismatch count and, optionally, the first failing location. It sits between a test/boot sequencer and `memory` as the automated replacement for hand-written write/read stimulus.

## Interface
Parameters:
- `W`, 1: word width in bytes; the data path is 8*W bits.
- `Addr_W`, 8: address MSB index; addresses are Addr_W+1 bits, [Addr_W:0], matching `memory`.
- `CNT_W`, 16: width of the mismatch counter.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `inp_start` input 1: start request; sampled only in IDLE.
- `inp_mode` input 2: 00 = fill, 01 = verify, 10 = fill then verify, 11 = same as 10.
- `inp_first` input Addr_W+1: first address, inclusive.
- `inp_last` input Addr_W+1: last address, inclusive.
- `inp_seed` input 8: pattern seed.
- `inp_read_data` input 8*W: connected to `memory.out_read_data`.
- `out_address` output Addr_W+1: connected to `memory.inp_address`.
- `out_data` output 8*W: connected to `memory.inp_data`.
- `out_write_enable` output 1: connected to `memory.write_enable`.
- `out_busy` output 1: high from the cycle after start is accepted until done.
- `out_done` output 1: one-cycle pulse at the end of an operation.
- `out_err_count` output CNT_W: number of mismatches in the last verify.
- `out_range_err` output 1: high when inp_first > inp_last at start; held until the next start.
- `out_first_err_addr` output Addr_W+1: first mismatching address.
- `out_first_err_data` output 8*W: data read at that address.

## Operation
- **Pattern.** Byte i of the word at address A = (A[7:0] + inp_seed + i) mod 256, for i = 0..W-1.
- **Latching at start.** inp_first, inp_last, inp_seed and inp_mode are latched when start is accepted. Later input changes have no effect until DONE.
- **FSM states:** IDLE, WRITE, READ, DRAIN, DONE.
- **IDLE.** If inp_start = 1:
  - Clear the count, range error and first-error capture.
  - If first > last: set out_range_err and go to DONE. No memory access occurs.
  - Otherwise go to WRITE (mode 00, 10 or 11) or READ (mode 01).
- **WRITE.** out_write_enable = 1, out_address steps first..last one per cycle, out_data = pattern(out_address). After last: go to READ (mode 10/11) or DONE (mode 00).
- **READ.** out_write_enable = 0, out_address steps first..last. The read is combinational in `memory`, so inp_read_data and the expected pattern are registered into a compare stage each cycle. After last: go to DRAIN.
- **DRAIN.** One cycle to retire the final compare, then go to DONE.
- **Compare stage.** Any inequality increments out_err_count, which saturates at 2^CNT_W-1.
- **DONE.** out_done = 1 for one cycle, then IDLE.
- **inp_start while busy** is ignored; no queueing.
- **Full-range scan** (first = 0, last = all-ones): the address counter terminates on equality with last, never on wrap, so there is no overflow.
- **Outside WRITE**, out_write_enable is 0 and out_data holds its last value.

## Timing
- Start is sampled at edge 0. With N = last-first+1:
  - Fill: write cycles 1..N, done in cycle N+1.
  - Verify: read cycles 1..N, drain in cycle N+1, done in cycle N+2.
  - Fill+verify: writes in cycles 1..N, reads in cycles N+1..2N, drain in cycle 2N+1, done in cycle 2N+2.
  - Range error: done in cycle 1.
- Compare latency is 1 cycle. The count is final when out_done is high.
- out_busy = 1 in WRITE, READ and DRAIN; 0 in IDLE and DONE.
- **Reset.** Immediately, regardless of clock: FSM = IDLE and all outputs = 0. This includes out_write_enable, so an in-flight write is aborted. Memory contents are not restored.

## Configuration
- Macro `MEM_SCAN_ERRLOG_EN`.
- **Defined:** on the first mismatch of a verify, out_first_err_addr and out_first_err_data capture that location and the data read. They hold until the next accepted start, which clears them to 0.
- **Undefined:** both outputs are tied to 0 and no capture registers exist. Counting is unaffected.

## Structure
- Package `mem_scan_pkg` contains:
  - the state enum (IDLE/WRITE/READ/DRAIN/DONE);
  - mode constants MODE_FILL = 2'b00, MODE_VERIFY = 2'b01, MODE_BOTH = 2'b10;
  - the pattern function (address, seed, byte index → byte).
- Sub-module `mem_scan_cmp` holds the registered compare stage and the saturating counter, plus the capture registers when `MEM_SCAN_ERRLOG_EN` is defined.

## Test plan
All scenarios use W=1, Addr_W=8 against `memory`.
- **Fill + verify.** Mode 10, first=0x00, last=0x03, seed=0x01 → writes 01, 02, 03, 04 at 00..03; done in cycle 10; err_count=0.
- **Corrupted verify.** After the fill above, the bench overwrites 0x02 with 0xFF, then runs mode 01 → err_count=1, done in cycle 6. With the macro: first_err_addr=0x02, first_err_data=0xFF.
- **Range error.** first=0x10, last=0x0F → range_err=1, no write_enable pulse, done in cycle 1.
- **Full range.** first=0x000, last=0x1FF, mode 00 → 512 consecutive writes; address never wraps; done in cycle 513.
- **Reset mid-operation.** Assert reset during WRITE at address 0x05 → write_enable, busy and done drop to 0 in the same cycle; the next start runs normally.
- **Start while busy.** Pulse start mid-READ, then use CNT_W=2 with 5 injected errors → second start ignored; err_count saturates at 3.
